layer_deserializer: RTL and testbench

Collects a word-serial stream of fixed-point samples (one `dataWidth` word per accepted beat) and packs `numInputs` of them into one parallel vector. The output has the same shape as a layer's `layerIn`/`layerValid` input pair. The block sits upstream of the first network layer: it converts pixel/feature streams from the host interface into the parallel vector that the layer's input serializer consumes. It is the inverse of the layer input serializer and uses valid/ready handshakes on both sides, plus frame-boundary checking.

---
 rtl/layer_deserializer.sv | 105 ++++++++++
 tb/tb_layer_deserializer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_deserializer.sv
// layer_deserializer
//
// Packs a word-serial stream of fixed-point samples into one parallel vector
// of numInputs words, shaped like a layer's layerIn/layerValid pair. Sample
// words are passed through bit-for-bit; no arithmetic is applied to them.
// Frame boundaries are checked against inLast: a frame that ends early or
// runs past numInputs words is reported on frameError and discarded.
//
// Ports
//   clk          in   single clock, rising-edge
//   reset        in   asynchronous, active-low; clears all state immediately
//   inData       in   [dataWidth]           incoming sample word
//   inValid      in   inData/inLast valid this cycle
//   inLast       in   final word of a frame (qualified by inValid)
//   inReady      out  a word can be accepted this cycle
//   vectorOut    out  [dataWidth*numInputs] packed vector, word k at
//                     [(k+1)*dataWidth-1 -: dataWidth]
//   vectorValid  out  vectorOut holds a complete frame
//   vectorReady  in   downstream accepts the vector
//   frameError   out  one-cycle pulse on frame length mismatch
//   wordCount    out  [counterWidth] words accepted into the current frame

module layer_deserializer #(
  parameter int dataWidth    = 16,
  parameter int numInputs    = 16,
  parameter int counterWidth = $clog2(numInputs + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [dataWidth-1:0]           inData,
  input  logic                           inValid,
  input  logic                           inLast,
  output logic                           inReady,
  output logic [dataWidth*numInputs-1:0] vectorOut,
  output logic                           vectorValid,
  input  logic                           vectorReady,
  output logic                           frameError,
  output logic [counterWidth-1:0]        wordCount
);

  localparam logic [counterWidth-1:0] LAST_IDX = counterWidth'(numInputs - 1);
  localparam logic [counterWidth-1:0] FULL_CNT = counterWidth'(numInputs);
  localparam logic [counterWidth-1:0] ONE      = counterWidth'(1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t state;
  logic   accept;
  logic   at_last_slot;

  assign accept       = inValid & inReady;
  assign at_last_slot = (wordCount == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FILL;
      inReady     <= 1'b0;
      vectorValid <= 1'b0;
      frameError  <= 1'b0;
      wordCount   <= '0;
      vectorOut   <= '0;
    end else begin
      frameError <= 1'b0;
      case (state)
        FILL: begin
          // inReady is held low through reset and first rises here.
          inReady <= 1'b1;
          if (accept) begin
            vectorOut[int'(wordCount)*dataWidth +: dataWidth] <= inData;
            if (at_last_slot && inLast) begin
              state       <= FULL;
              inReady     <= 1'b0;
              vectorValid <= 1'b1;
              wordCount   <= FULL_CNT;
            end else if (!at_last_slot && !inLast) begin
              wordCount <= wordCount + ONE;
            end else begin
              // Short or over-long frame: restart at slot 0. Stale slots are
              // never exposed because vectorValid stays low until a clean
              // frame has overwritten every slot.
              frameError <= 1'b1;
              wordCount  <= '0;
            end
          end
        end
        FULL: begin
          // vectorOut stays frozen until the downstream handshake.
          if (vectorReady) begin
            state       <= FILL;
            inReady     <= 1'b1;
            vectorValid <= 1'b0;
            wordCount   <= '0;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_deserializer.sv
// Testbench for layer_deserializer (numInputs=4, dataWidth=16).
// Directed steps for each scenario, then 200 random frames with random
// input gaps and output stalls, all checked cycle by cycle against a
// queue-based reference model plus an end-to-end frame scoreboard.

module tb_layer_deserializer;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);
  localparam int NFRAMES = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     inData;
  logic              inValid;
  logic              inLast;
  logic              inReady;
  logic [DW*N-1:0]   vectorOut;
  logic              vectorValid;
  logic              vectorReady;
  logic              frameError;
  logic [CW-1:0]     wordCount;

  always #5 clk = ~clk;

  layer_deserializer #(
    .dataWidth(DW),
    .numInputs(N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inData(inData),
    .inValid(inValid),
    .inLast(inLast),
    .inReady(inReady),
    .vectorOut(vectorOut),
    .vectorValid(vectorValid),
    .vectorReady(vectorReady),
    .frameError(frameError),
    .wordCount(wordCount)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: words collected so far in the current frame.
  logic [DW-1:0]   mq[$];
  bit              m_full;
  bit              m_ready;
  bit              m_err;
  bit              m_acc;
  logic [DW*N-1:0] m_vec;

  // End-to-end scoreboard for the random phase.
  logic [DW*N-1:0] exp_q[$];
  logic [DW-1:0]   stream[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_full  = 1'b0;
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_acc   = 1'b0;
  endtask

  // Applies one rising edge worth of behaviour using the pre-edge inputs.
  task automatic model_edge();
    m_err = 1'b0;
    m_acc = 1'b0;
    if (!reset) begin
      model_reset();
    end else if (m_full) begin
      if (vectorReady) begin
        m_full  = 1'b0;
        m_ready = 1'b1;
        mq.delete();
      end
    end else begin
      m_acc   = inValid && m_ready;
      m_ready = 1'b1;
      if (m_acc) begin
        mq.push_back(inData);
        if (inLast && mq.size() == N) begin
          m_full  = 1'b1;
          m_ready = 1'b0;
          for (int k = 0; k < N; k++) m_vec[k*DW +: DW] = mq[k];
        end else if (inLast || mq.size() == N) begin
          m_err = 1'b1;
          mq.delete();
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("inReady",     64'(inReady),     64'(m_ready));
    chk("vectorValid", 64'(vectorValid), 64'(m_full));
    chk("frameError",  64'(frameError),  64'(m_err));
    chk("wordCount",   64'(wordCount),   64'(mq.size()));
    if (m_full) chk("vectorOut", 64'(vectorOut), 64'(m_vec));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [DW-1:0] w, input bit last);
    inValid = 1'b1;
    inData  = w;
    inLast  = last;
    tick();
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk({tag, "_vv"}, 64'(vectorValid), 64'd0);
    chk({tag, "_vo"}, 64'(vectorOut),   64'd0);
    chk({tag, "_wc"}, 64'(wordCount),   64'd0);
    chk({tag, "_ir"}, 64'(inReady),     64'd0);
    #2 reset = 1'b1;
    tick();
    chk({tag, "_ir_rise"}, 64'(inReady), 64'd1);
  endtask

  initial begin
    int pos;
    int delivered;
    int cycles;
    logic [DW*N-1:0] v;

    reset       = 1'b1;
    inData      = '0;
    inValid     = 1'b0;
    inLast      = 1'b0;
    vectorReady = 1'b1;
    model_reset();

    // Reset state
    #1 reset = 1'b0;
    #1;
    chk("rst_ir", 64'(inReady),     64'd0);
    chk("rst_vv", 64'(vectorValid), 64'd0);
    chk("rst_vo", 64'(vectorOut),   64'd0);
    chk("rst_fe", 64'(frameError),  64'd0);
    chk("rst_wc", 64'(wordCount),   64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_release_ir", 64'(inReady), 64'd1);

    // Basic frame
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b0);
    send(16'h0004, 1'b1);
    chk("basic_vo", 64'(vectorOut),   64'h0004_0003_0002_0001);
    chk("basic_vv", 64'(vectorValid), 64'd1);
    chk("basic_ir", 64'(inReady),     64'd0);
    tick();
    chk("basic_vv_one_cycle", 64'(vectorValid), 64'd0);

    // Output backpressure
    vectorReady = 1'b0;
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b0);
    send(16'h0004, 1'b1);
    inValid = 1'b1;
    inData  = 16'h0055;
    inLast  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_vo_stable", 64'(vectorOut), 64'h0004_0003_0002_0001);
      chk("bp_ir_low",    64'(inReady),   64'd0);
    end
    vectorReady = 1'b1;
    tick();
    chk("bp_release_ir", 64'(inReady), 64'd1);
    tick();
    chk("bp_next_accepted_wc", 64'(wordCount), 64'd1);
    send(16'h0066, 1'b0);
    send(16'h0077, 1'b0);
    send(16'h0088, 1'b1);
    chk("bp_next_vo", 64'(vectorOut), 64'h0088_0077_0066_0055);
    tick();

    // Short frame
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b1);
    chk("short_fe", 64'(frameError),  64'd1);
    chk("short_wc", 64'(wordCount),   64'd0);
    chk("short_vv", 64'(vectorValid), 64'd0);
    send(16'h0011, 1'b0);
    chk("short_fe_pulse_end", 64'(frameError), 64'd0);
    send(16'h0022, 1'b0);
    send(16'h0033, 1'b0);
    send(16'h0044, 1'b1);
    chk("short_next_vo", 64'(vectorOut), 64'h0044_0033_0022_0011);
    tick();

    // Long frame
    send(16'h0101, 1'b0);
    send(16'h0202, 1'b0);
    send(16'h0303, 1'b0);
    send(16'h0404, 1'b0);
    chk("long_fe", 64'(frameError),  64'd1);
    chk("long_vv", 64'(vectorValid), 64'd0);
    chk("long_ir", 64'(inReady),     64'd1);
    send(16'h0005, 1'b0);
    send(16'h0006, 1'b0);
    send(16'h0007, 1'b0);
    send(16'h0008, 1'b1);
    chk("long_next_vo", 64'(vectorOut), 64'h0008_0007_0006_0005);
    tick();

    // Reset mid-frame
    send(16'h0909, 1'b0);
    send(16'h0A0A, 1'b0);
    async_reset_check("rst_mid");
    send(16'h00B1, 1'b0);
    send(16'h00B2, 1'b0);
    send(16'h00B3, 1'b0);
    vectorReady = 1'b0;
    send(16'h00B4, 1'b1);
    chk("rst_mid_fresh_vo", 64'(vectorOut), 64'h00B4_00B3_00B2_00B1);
    tick();

    // Reset while FULL
    async_reset_check("rst_full");
    vectorReady = 1'b1;
    send(16'h00C1, 1'b0);
    send(16'h00C2, 1'b0);
    send(16'h00C3, 1'b0);
    send(16'h00C4, 1'b1);
    chk("rst_full_fresh_vo", 64'(vectorOut), 64'h00C4_00C3_00C2_00C1);
    tick();

    // Random gaps and stalls
    for (int f = 0; f < NFRAMES; f++) begin
      for (int k = 0; k < N; k++) begin
        v[k*DW +: DW] = DW'($urandom);
        stream.push_back(v[k*DW +: DW]);
      end
      exp_q.push_back(v);
    end
    pos       = 0;
    delivered = 0;
    cycles    = 0;
    while (delivered < NFRAMES && cycles < 20000) begin
      inValid     = (pos < stream.size()) && ($urandom_range(0, 3) != 0);
      inData      = (pos < stream.size()) ? stream[pos] : DW'($urandom);
      inLast      = ((pos % N) == N - 1);
      vectorReady = ($urandom_range(0, 2) != 0);
      if (vectorValid && vectorReady) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra_vector", 64'(exp_q.size()), 64'd1);
        end else begin
          chk("sb_vec", 64'(vectorOut), 64'(exp_q.pop_front()));
        end
        delivered++;
      end
      tick();
      if (m_acc) pos++;
      cycles++;
    end
    chk("sb_delivered", 64'(delivered),    64'(NFRAMES));
    chk("sb_remaining", 64'(exp_q.size()), 64'd0);
    chk("sb_words",     64'(pos),          64'(NFRAMES * N));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
